vga_line_buffer: RTL
====================

VGA_LINE_BUFFER -- requirements
Module: vga_line_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count, power of two, minimum 4.
REQ-002 SHALL have parameter ADDR_W, default 4, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single system/pixel clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_valid  input  1  producer offers a pixel.
REQ-006 SHALL have port wr_data  input  12  pixel {red[11:8], grn[7:4], blu[3:0]}.
REQ-007 SHALL have port wr_ready  output  1  buffer can accept wr_data this cycle.
REQ-008 SHALL have port pix_req  input  1  VGA timing stage requests one pixel (active video).
REQ-009 SHALL have port frame_sync  input  1  one-cycle pulse at frame start; flushes the buffer.
REQ-010 SHALL have port redvga  output  4  registered red to the VGA timing stage.
REQ-011 SHALL have port grnvga  output  4  registered green.
REQ-012 SHALL have port bluvga  output  4  registered blue.
REQ-013 SHALL have port level  output  ADDR_W+1  current entry count, 0..DEPTH.
REQ-014 SHALL have port underflow  output  1  sticky: pix_req seen while empty.

Function
REQ-015 SHALL store pixels in a DEPTH-entry circular FIFO with ADDR_W-bit read/write pointers wrapping modulo DEPTH.
REQ-016 SHALL drive wr_ready = (level < DEPTH) AND NOT frame_sync AND rst_n, combinationally.
REQ-017 SHALL write wr_data at the write pointer and advance it only when wr_valid AND wr_ready.
REQ-018 SHALL, when pix_req AND level > 0, pop the entry at the read pointer and present it on redvga/grnvga/bluvga at the next rising edge (1-cycle latency).
REQ-019 SHALL, when pix_req AND level == 0, drive 0 on all colour outputs next cycle, set underflow, and leave pointers unchanged.
REQ-020 SHALL, when pix_req is low, drive 0 on all colour outputs next cycle (blanking), without popping.
REQ-021 SHALL update level by +1 on a write only, -1 on a pop only, unchanged on simultaneous write and pop.
REQ-022 SHALL NOT bypass: a write into an empty FIFO is poppable no earlier than the following cycle; same-cycle pix_req still counts as underflow.
REQ-023 SHALL hold level at DEPTH when full; wr_ready low prevents overflow, and a simultaneous pop raises wr_ready only the next cycle.
REQ-024 SHALL, on frame_sync, reset both pointers and level to 0, clear underflow, discard any same-cycle write and pop, and drive colour outputs 0 next cycle; frame_sync has priority over all other events.
REQ-025 SHALL keep underflow set until frame_sync or reset, regardless of later successful pops.
REQ-026 SHALL NOT reset FIFO storage contents; only pointers, level and flags.

Reset
REQ-027 SHALL, while rst_n is low, immediately force pointers=0, level=0, underflow=0, redvga=grnvga=bluvga=0, wr_ready=0.
REQ-028 SHALL assert wr_ready in the first cycle after rst_n deasserts, provided frame_sync is low.
REQ-029 SHALL discard all buffered pixels on reset asserted mid-operation; no pops occur until new writes arrive.

Verification
REQ-030 Fill/drain: reset, write 0x123,0x456,0x789, then pix_req 3 cycles -> colour outputs (r,g,b) = (1,2,3),(4,5,6),(7,8,9) one cycle after each request; level 3->0; underflow 0.
REQ-031 Full: wr_valid held high 20 cycles, pix_req low -> level reaches 16, wr_ready 0 from then, exactly 16 writes accepted; one pix_req -> level 15, wr_ready 1 next cycle.
REQ-032 Underflow: empty FIFO, pix_req 1 cycle -> outputs 0, underflow=1; write 0xFFF, pop -> outputs (F,F,F), underflow still 1; frame_sync -> underflow 0.
REQ-033 Simultaneous: level 5, wr_valid and pix_req high 10 cycles -> level stays 5, output order matches write order across pointer wrap.
REQ-034 Flush priority: level 8, frame_sync with wr_valid and pix_req high same cycle -> level 0, wr_ready 0 that cycle, outputs 0 next cycle, no write stored.
REQ-035 Async reset: rst_n pulsed low mid-cycle at level 10 -> outputs and level 0 before next edge, wr_ready 0 during reset, 1 one cycle after release.

Source files
------------

// File: rtl/vga_line_buffer.sv
// rtl/vga_line_buffer.sv - pixel FIFO between a pixel producer and the VGA timing stage
module vga_line_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [11:0]       wr_data,
    output logic              wr_ready,
    input  logic              pix_req,
    input  logic              frame_sync,
    output logic [3:0]        redvga,
    output logic [3:0]        grnvga,
    output logic [3:0]        bluvga,
    output logic [ADDR_W:0]   level,
    output logic              underflow
);

    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(DEPTH);

    // Storage is deliberately left without reset; only pointers and flags define validity.
    logic [11:0]       mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              underflow_q, underflow_d;
    logic [11:0]       rgb_q, rgb_d;

    logic              do_write;
    logic              do_pop;
    logic              is_empty;

    // Acceptance is combinational so the producer sees back-pressure in the same cycle;
    // a pop at full only frees space from the next cycle because level_q is registered.
    assign wr_ready = (level_q < LVL_FULL) && !frame_sync && rst_n;
    assign is_empty = (level_q == '0);
    assign do_write = wr_valid && wr_ready;
    // No bypass: a pixel written this cycle is not visible to pix_req until level_q counts it.
    assign do_pop   = pix_req && !is_empty && !frame_sync;

    // Next-state for pointers, level, sticky underflow and the registered colour word.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        underflow_d = underflow_q;
        rgb_d       = 12'h000;
        if (frame_sync) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            underflow_d = 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                rgb_d    = mem_q[rd_ptr_q];
            end
            if (pix_req && is_empty) begin
                underflow_d = 1'b1;
            end
            unique case ({do_write, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Control state register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            underflow_q <= 1'b0;
            rgb_q       <= 12'h000;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
            rgb_q       <= rgb_d;
        end
    end

    // Pixel storage write port.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign redvga    = rgb_q[11:8];
    assign grnvga    = rgb_q[7:4];
    assign bluvga    = rgb_q[3:0];
    assign level     = level_q;
    assign underflow = underflow_q;

endmodule
